register_flags_bank: RTL and testbench

//  Parametrised CPU flag register: NFLAGS flags in one active bank, NSHADOW shadow banks and a STACK_DEPTH save/restore LIFO.

---
 rtl/register_flags_pkg.sv | 20 ++
 rtl/register_flags_lifo.sv | 55 +++++
 rtl/register_flags_bank.sv | 73 +++++++
 tb/tb_register_flags_bank.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/register_flags_pkg.sv
// register_flags_pkg: flag/source indices and the AND-OR source select helper.
package register_flags_pkg;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_P = 3;
  localparam int SRC_ONE    = 0;
  localparam int SRC_CY8    = 1;
  localparam int SRC_NCY8   = 2;
  localparam int SRC_S_OR_C = 3;
  localparam int SRC_CY16   = 4;
  localparam int SRC_NCY16  = 5;
  localparam int SRC_LOW0   = 6;
  localparam int SRC_LOW7   = 7;
  localparam int SRC_MAX    = 64;
  // Callers zero-extend their NSRC-wide slices, so unused lanes never select.
  function automatic logic sel_or(input logic [SRC_MAX-1:0] src, input logic [SRC_MAX-1:0] sel);
    return |(src & sel);
  endfunction
endpackage

// File: rtl/register_flags_lifo.sv
// register_flags_lifo: save/restore stack with same-cycle swap, saturating depth and sticky ovf/unf.
module register_flags_lifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       err_clr_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               top_o,
  output logic                       pop_ok_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_o,
  output logic                       unf_o
);
  localparam int DW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          full_q, empty_q, ovf_q, unf_q, swap, push_ok;
  always_comb begin
    pop_ok_o = pop_i & ~empty_q;
    swap     = push_i & pop_ok_o;
    push_ok  = push_i & ~pop_i & ~full_q;
    depth_d  = push_ok ? depth_q + DW'(1) : (pop_ok_o & ~push_i) ? depth_q - DW'(1) : depth_q;
    top_o    = '0;
    for (int k = 0; k < DEPTH; k++) if (DW'(k+1) == depth_q) top_o = mem_q[k];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        if ((swap && DW'(k+1) == depth_q) || (push_ok && DW'(k) == depth_q)) mem_q[k] <= din_i;
      depth_q <= depth_d;
      full_q  <= depth_d == DW'(DEPTH);
      empty_q <= depth_d == '0;
      ovf_q   <= (push_i & ~pop_i & full_q) | (ovf_q & ~err_clr_i);
      unf_q   <= (pop_i & empty_q) | (unf_q & ~err_clr_i);
    end
  end
  assign depth_o = depth_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
endmodule

// File: rtl/register_flags_bank.sv
// register_flags_bank: active flag register with per-flag source select, shadow banks and a save/restore LIFO.
module register_flags_bank
  import register_flags_pkg::*;
#(
  parameter int NFLAGS      = 8,
  parameter int NSRC        = 8,
  parameter int NSHADOW     = 2,
  parameter int STACK_DEPTH = 4,
  localparam int EXW        = NSHADOW > 1 ? $clog2(NSHADOW) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NFLAGS*NSRC-1:0]           src_i,
  input  logic [NFLAGS*NSRC-1:0]           sel_i,
  input  logic [NFLAGS-1:0]                we_i,
  input  logic                             load_i,
  input  logic [NFLAGS-1:0]                load_data_i,
  input  logic                             ex_i,
  input  logic [EXW-1:0]                   ex_bank_i,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic                             err_clr_i,
  output logic [NFLAGS-1:0]                flags_o,
  output logic [NFLAGS-1:0]                not_flags_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic                             ovf_o,
  output logic                             unf_o
);
  logic [NFLAGS-1:0] flags_q, flags_d, nflags_q, upd, shadow_rd, top;
  logic [NFLAGS-1:0] shadow_q [NSHADOW];
  logic [EXW-1:0]    bank;
  logic              pop_ok;
  assign bank = NSHADOW > 1 ? ex_bank_i : '0;
  always_comb begin
    upd = flags_q;
    for (int i = 0; i < NFLAGS; i++)
      if (we_i[i]) upd[i] = sel_or(SRC_MAX'(src_i[i*NSRC +: NSRC]), SRC_MAX'(sel_i[i*NSRC +: NSRC]));
    shadow_rd = '0;
    for (int s = 0; s < NSHADOW; s++) if (EXW'(s) == bank) shadow_rd = shadow_q[s];
    flags_d = load_i ? load_data_i : pop_ok ? top : ex_i ? shadow_rd : upd;
  end
  // Shadow capture uses the pre-edge value even when load or pop owns the active path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q  <= '0;
      nflags_q <= '1;
      for (int s = 0; s < NSHADOW; s++) shadow_q[s] <= '0;
    end else begin
      flags_q  <= flags_d;
      nflags_q <= ~flags_d;
      for (int s = 0; s < NSHADOW; s++) if (ex_i && EXW'(s) == bank) shadow_q[s] <= flags_q;
    end
  end
  register_flags_lifo #(.W(NFLAGS), .DEPTH(STACK_DEPTH)) u_lifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push_i),
    .pop_i     (pop_i),
    .err_clr_i (err_clr_i),
    .din_i     (flags_q),
    .top_o     (top),
    .pop_ok_o  (pop_ok),
    .depth_o   (depth_o),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .ovf_o     (ovf_o),
    .unf_o     (unf_o)
  );
  assign flags_o     = flags_q;
  assign not_flags_o = nflags_q;
endmodule

// File: tb/tb_register_flags_bank.sv
// tb_register_flags_bank: directed scenario tasks with hand-computed expectations for register_flags_bank.
module tb_register_flags_bank;
  import register_flags_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [63:0] src = '0, sel = '0;
  logic [7:0]  we = '0, load_data = '0;
  logic        load = 1'b0, ex = 1'b0, ex_bank = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [7:0]  flags, nflags;
  logic [2:0]  depth;
  logic        full, empty, ovf, unf;
  int          n_cmp = 0, n_bad = 0;

  register_flags_bank dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .sel_i(sel), .we_i(we),
    .load_i(load), .load_data_i(load_data), .ex_i(ex), .ex_bank_i(ex_bank),
    .push_i(push), .pop_i(pop), .err_clr_i(err_clr),
    .flags_o(flags), .not_flags_o(nflags), .depth_o(depth),
    .full_o(full), .empty_o(empty), .ovf_o(ovf), .unf_o(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] v);
    load = 1'b1; load_data = v; step(); load = 1'b0;
  endtask

  task automatic pu();
    push = 1'b1; step(); push = 1'b0;
  endtask

  task automatic po();
    pop = 1'b1; step(); pop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    n_cmp++; if (flags !== 8'h00) begin n_bad++; $display("FAIL rst_flags got=%h exp=00", flags); end
    n_cmp++; if (nflags !== 8'hFF) begin n_bad++; $display("FAIL rst_nflags got=%h exp=ff", nflags); end
    n_cmp++; if ({depth, full, empty, ovf, unf} !== 7'b000_0100) begin n_bad++; $display("FAIL rst_status got=%b exp=0000100", {depth, full, empty, ovf, unf}); end
    ld(8'hAA); pu();
    ex = 1'b1; ex_bank = 1'b0; step(); ex = 1'b0;
    ld(8'h55);
    #2 rst_n = 1'b0; #1;
    n_cmp++; if (flags !== 8'h00 || nflags !== 8'hFF) begin n_bad++; $display("FAIL async_rst flags=%h nflags=%h exp=00/ff", flags, nflags); end
    n_cmp++; if (depth !== 3'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL async_rst_lifo depth=%0d empty=%b exp=0/1", depth, empty); end
    rst_n = 1'b1;
    ex = 1'b1; ex_bank = 1'b0; step(); ex = 1'b0;
    n_cmp++; if (flags !== 8'h00) begin n_bad++; $display("FAIL rst_shadow got=%h exp=00", flags); end
  endtask

  task automatic test_source();
    logic [7:0] pat;
    we = 8'h01; sel = '0; src = '0;
    sel[FLAG_C*8+SRC_ONE] = 1'b1; src[FLAG_C*8+SRC_ONE] = 1'b1;
    step();
    n_cmp++; if (flags !== 8'h01) begin n_bad++; $display("FAIL src_one got=%h exp=01", flags); end
    sel = '0; step();
    n_cmp++; if (flags !== 8'h00) begin n_bad++; $display("FAIL src_clear got=%h exp=00", flags); end
    we = 8'h02; src = 64'hFFFF_FFFF_FFFF_7FFF; sel = '0;
    sel[FLAG_Z*8+SRC_LOW7] = 1'b1; src[FLAG_Z*8+SRC_LOW7] = 1'b1;
    step();
    n_cmp++; if (flags !== 8'h02) begin n_bad++; $display("FAIL src_low7 got=%h exp=02", flags); end
    we = 8'h00; sel = '1; src = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (flags !== 8'h02) begin n_bad++; $display("FAIL hold%0d got=%h exp=02", c, flags); end
    end
    pat = 8'hC6; we = 8'hFF; sel = '0; src = '0;
    for (int i = 0; i < 8; i++) begin sel[i*8+i] = 1'b1; src[i*8+i] = pat[i]; end
    src[FLAG_C*8+SRC_LOW7] = 1'b1;
    step();
    n_cmp++; if (flags !== 8'hC6) begin n_bad++; $display("FAIL src_all got=%h exp=c6", flags); end
    n_cmp++; if (nflags !== 8'h39) begin n_bad++; $display("FAIL src_all_n got=%h exp=39", nflags); end
    we = 8'h01; sel = 64'h3; src = 64'h2; step();
    n_cmp++; if (flags !== 8'hC7) begin n_bad++; $display("FAIL src_multihot got=%h exp=c7", flags); end
    we = '0; sel = '0; src = '0;
  endtask

  task automatic test_exchange();
    ld(8'h3C);
    ex = 1'b1; ex_bank = 1'b1; step(); ex = 1'b0;
    n_cmp++; if (flags !== 8'h00) begin n_bad++; $display("FAIL ex_init got=%h exp=00", flags); end
    ld(8'hA5);
    ex = 1'b1; step();
    n_cmp++; if (flags !== 8'h3C || nflags !== 8'hC3) begin n_bad++; $display("FAIL ex1 flags=%h nflags=%h exp=3c/c3", flags, nflags); end
    step(); ex = 1'b0;
    n_cmp++; if (flags !== 8'hA5) begin n_bad++; $display("FAIL ex2 got=%h exp=a5", flags); end
    ex = 1'b1; ex_bank = 1'b0; step();
    n_cmp++; if (flags !== 8'h00) begin n_bad++; $display("FAIL ex_bank0 got=%h exp=00", flags); end
    step(); ex = 1'b0;
    n_cmp++; if (flags !== 8'hA5) begin n_bad++; $display("FAIL ex_bank0_back got=%h exp=a5", flags); end
  endtask

  task automatic test_lifo();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      ld(vals[i]); pu();
      n_cmp++; if (depth !== 3'(i+1) || full !== (i == 3)) begin n_bad++; $display("FAIL push%0d depth=%0d full=%b exp=%0d/%b", i, depth, full, i+1, i == 3); end
    end
    pu();
    n_cmp++; if (ovf !== 1'b1 || depth !== 3'd4 || full !== 1'b1) begin n_bad++; $display("FAIL push_full ovf=%b depth=%0d full=%b exp=1/4/1", ovf, depth, full); end
    ld(8'h00);
    for (int i = 3; i >= 0; i--) begin
      po();
      n_cmp++; if (flags !== vals[i] || depth !== 3'(i)) begin n_bad++; $display("FAIL pop%0d flags=%h depth=%0d exp=%h/%0d", i, flags, depth, vals[i], i); end
    end
    n_cmp++; if (empty !== 1'b1 || unf !== 1'b0) begin n_bad++; $display("FAIL drained empty=%b unf=%b exp=1/0", empty, unf); end
    po();
    n_cmp++; if (flags !== 8'h11 || unf !== 1'b1 || depth !== 3'd0) begin n_bad++; $display("FAIL pop_empty flags=%h unf=%b depth=%0d exp=11/1/0", flags, unf, depth); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_bad++; $display("FAIL err_clr ovf=%b unf=%b exp=0/0", ovf, unf); end
  endtask

  task automatic test_collisions();
    ld(8'h77);
    load = 1'b1; load_data = 8'h5A; ex = 1'b1; ex_bank = 1'b1; step(); load = 1'b0; ex = 1'b0;
    n_cmp++; if (flags !== 8'h5A) begin n_bad++; $display("FAIL load_ex got=%h exp=5a", flags); end
    ex = 1'b1; step(); ex = 1'b0;
    n_cmp++; if (flags !== 8'h77) begin n_bad++; $display("FAIL load_ex_shadow got=%h exp=77", flags); end
    ld(8'hAB); pu(); ld(8'hF0); pu(); ld(8'h0F);
    push = 1'b1; pop = 1'b1; step(); push = 1'b0; pop = 1'b0;
    n_cmp++; if (flags !== 8'hF0 || depth !== 3'd2) begin n_bad++; $display("FAIL swap flags=%h depth=%0d exp=f0/2", flags, depth); end
    po();
    n_cmp++; if (flags !== 8'h0F || depth !== 3'd1) begin n_bad++; $display("FAIL swap_top flags=%h depth=%0d exp=0f/1", flags, depth); end
    po();
    n_cmp++; if (flags !== 8'hAB || empty !== 1'b1) begin n_bad++; $display("FAIL swap_bottom flags=%h empty=%b exp=ab/1", flags, empty); end
    push = 1'b1; pop = 1'b1; step(); push = 1'b0; pop = 1'b0;
    n_cmp++; if (flags !== 8'hAB || unf !== 1'b1 || depth !== 3'd0) begin n_bad++; $display("FAIL swap_empty flags=%h unf=%b depth=%0d exp=ab/1/0", flags, unf, depth); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    ld(8'h12); pu(); ld(8'h34);
    pop = 1'b1; ex = 1'b1; ex_bank = 1'b0; step(); pop = 1'b0; ex = 1'b0;
    n_cmp++; if (flags !== 8'h12) begin n_bad++; $display("FAIL pop_over_ex got=%h exp=12", flags); end
    ex = 1'b1; step(); ex = 1'b0;
    n_cmp++; if (flags !== 8'h34) begin n_bad++; $display("FAIL pop_ex_shadow got=%h exp=34", flags); end
  endtask

  task automatic test_sticky();
    for (int i = 0; i < 4; i++) pu();
    n_cmp++; if (full !== 1'b1 || ovf !== 1'b0) begin n_bad++; $display("FAIL sticky_fill full=%b ovf=%b exp=1/0", full, ovf); end
    push = 1'b1; err_clr = 1'b1; step(); push = 1'b0;
    n_cmp++; if (ovf !== 1'b1 || depth !== 3'd4) begin n_bad++; $display("FAIL sticky_win ovf=%b depth=%0d exp=1/4", ovf, depth); end
    step(); err_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL sticky_clear ovf=%b exp=0", ovf); end
  endtask

  initial begin
    test_reset();
    test_source();
    test_exchange();
    test_lifo();
    test_collisions();
    test_sticky();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
